// File: rtl/fifo_syn_pkg.sv
// Shared read-mode constants and pointer/count helpers for the single-clock FIFO.
package fifo_syn_pkg;

    localparam string FIFO_MODE_STD  = "std";
    localparam string FIFO_MODE_FWFT = "fwft";

    // Bits needed to hold an occupancy of 0..2^addr_width inclusive.
    function automatic int unsigned fifo_cnt_width(input int unsigned addr_width);
        return $clog2((1 << addr_width) + 1);
    endfunction

    function automatic logic fifo_ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                           input int unsigned addr_width);
        logic [31:0] mask;
        mask = (32'd1 << (addr_width + 1)) - 32'd1;
        return ((wptr ^ rptr) & mask) == (32'd1 << addr_width);
    endfunction

    function automatic logic fifo_ptr_empty(input logic [31:0] wptr, input logic [31:0] rptr);
        return wptr == rptr;
    endfunction

endpackage

// File: rtl/fifo_syn_ptr_ctrl.sv
// Pointer, occupancy count and status-flag logic for fifo_syn_mode.
module fifo_syn_ptr_ctrl
    import fifo_syn_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  rd_avail_i,
    input  logic                  st_rd_i,
    output logic                  wr_acc_o,
    output logic                  rd_acc_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  st_empty_o,
    output logic [ADDR_WIDTH:0]   data_count_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int unsigned CW    = fifo_cnt_width(ADDR_WIDTH);
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, afull_q, aempty_q, ovf_q, unf_q;

    assign wr_acc_o   = wr_en_i && !full_q;
    assign rd_acc_o   = rd_en_i && rd_avail_i;
    assign st_empty_o = fifo_ptr_empty(32'(wptr_q), 32'(rptr_q));

    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc_o && !rd_acc_o) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_acc_o && rd_acc_o) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Flags come from next-state count so they change on the same edge as the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc_o) wptr_q <= wptr_q + PW'(1);
            if (st_rd_i)  rptr_q <= rptr_q + PW'(1);
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CW'(DEPTH));
            afull_q  <= (cnt_d >= CW'(AFULL_THRESH));
            aempty_q <= (cnt_d <= CW'(AEMPTY_THRESH));
            ovf_q    <= wr_en_i && full_q;
            unf_q    <= rd_en_i && !rd_avail_i;
        end
    end

    assign wr_addr_o      = wptr_q[ADDR_WIDTH-1:0];
    assign rd_addr_o      = rptr_q[ADDR_WIDTH-1:0];
    assign data_count_o   = cnt_q;
    assign full_o         = full_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: port A writes, port B reads through a registered output.
module ram_sdp #(
    parameter int unsigned DATA_WIDTH       = 36,
    parameter int unsigned ADDR_WIDTH       = 10,
    parameter int unsigned DOUT_PIPE_NUMBER = 1,
    parameter string       RAM_TYPE         = "block"
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  clkb,
    input  logic                  rstb,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);
    if (DOUT_PIPE_NUMBER != 1) begin : g_bad_pipe
        $error("ram_sdp: only DOUT_PIPE_NUMBER=1 is supported");
    end
    if (RAM_TYPE != "block" && RAM_TYPE != "distributed" && RAM_TYPE != "registers")
    begin : g_bad_type
        $error("ram_sdp: RAM_TYPE must be block, distributed or registers");
    end

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    // Output register holds its value while enb is low.
    always_ff @(posedge clkb) begin
        if (rstb) begin
            dout_q <= '0;
        end else if (enb) begin
            dout_q <= mem[addrb];
        end
    end

    assign doutb = dout_q;

endmodule

// File: rtl/fifo_syn_mode.sv
// Single-clock FIFO with "std" (registered read) or "fwft" read mode.
// Define FIFO_SYN_WATERMARK_EN to add the peak_count / peak_clr occupancy watermark.
module fifo_syn_mode
    import fifo_syn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 36,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter string       READ_MODE     = "std",
    parameter string       RAM_TYPE      = "block",
    parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   data_count
`ifdef FIFO_SYN_WATERMARK_EN
    ,
    input  logic                  peak_clr,
    output logic [ADDR_WIDTH:0]   peak_count
`endif
);
    localparam bit FWFT = (READ_MODE == FIFO_MODE_FWFT);

    if (AFULL_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_afull
        $error("fifo_syn_mode: AFULL_THRESH exceeds FIFO depth");
    end
    if (READ_MODE != FIFO_MODE_STD && !FWFT) begin : g_bad_mode
        $error("fifo_syn_mode: READ_MODE must be \"std\" or \"fwft\"");
    end

    logic                  wr_acc, rd_acc, st_rd, st_empty, rd_avail;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    fifo_syn_ptr_ctrl #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_ptr_ctrl (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .rd_en_i        (rd_en),
        .rd_avail_i     (rd_avail),
        .st_rd_i        (st_rd),
        .wr_acc_o       (wr_acc),
        .rd_acc_o       (rd_acc),
        .wr_addr_o      (wr_addr),
        .rd_addr_o      (rd_addr),
        .st_empty_o     (st_empty),
        .data_count_o   (data_count),
        .full_o         (full),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    if (FWFT) begin : g_fwft
        // The RAM output register doubles as the head-word register; refill it whenever it
        // is empty or being popped and storage still holds words.
        assign rd_avail = valid_q;
        assign st_rd    = !st_empty && (!valid_q || rd_acc);
        assign valid_d  = st_rd || (valid_q && !rd_acc);
        assign empty    = !valid_q;
    end else begin : g_std
        assign rd_avail = !st_empty;
        assign st_rd    = rd_acc;
        assign valid_d  = rd_acc;
        assign empty    = st_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_valid = valid_q;

    ram_sdp #(
        .DATA_WIDTH       (DATA_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .DOUT_PIPE_NUMBER (1),
        .RAM_TYPE         (RAM_TYPE)
    ) u_ram (
        .clka  (clk),
        .ena   (wr_acc),
        .wea   (wr_acc),
        .addra (wr_addr),
        .dina  (wr_data),
        .clkb  (clk),
        .rstb  (rst),
        .enb   (st_rd),
        .addrb (rd_addr),
        .doutb (rd_data)
    );

`ifdef FIFO_SYN_WATERMARK_EN
    logic [ADDR_WIDTH:0] peak_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= data_count;
        end else if (data_count > peak_q) begin
            peak_q <= data_count;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_fifo_syn_mode.sv
// Randomised bench for fifo_syn_mode: one std and one fwft instance driven with the same
// stimulus and compared every cycle against a queue-based reference model.
module tb_fifo_syn_mode;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 1 << AW;
    localparam int          AFT   = DEPTH - 4;
    localparam int          AET   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [1:0]    full, afull, ovf, rvalid, empty, aempty, unf;
    logic [DW-1:0] rdata [2];
    logic [AW:0]   cnt [2];
`ifdef FIFO_SYN_WATERMARK_EN
    logic          peak_clr = 1'b0;
    logic [AW:0]   peak [2];
    int            e_peak [2];
`endif

    always #5 clk = ~clk;

    fifo_syn_mode #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .READ_MODE ("std")
    ) u_std (
        .clk (clk), .rst (rst), .wr_data (wr_data), .wr_en (wr_en), .full (full[0]),
        .almost_full (afull[0]), .overflow (ovf[0]), .rd_en (rd_en), .rd_data (rdata[0]),
        .rd_valid (rvalid[0]), .empty (empty[0]), .almost_empty (aempty[0]),
        .underflow (unf[0]), .data_count (cnt[0])
`ifdef FIFO_SYN_WATERMARK_EN
        , .peak_clr (peak_clr), .peak_count (peak[0])
`endif
    );

    fifo_syn_mode #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .READ_MODE ("fwft")
    ) u_fwft (
        .clk (clk), .rst (rst), .wr_data (wr_data), .wr_en (wr_en), .full (full[1]),
        .almost_full (afull[1]), .overflow (ovf[1]), .rd_en (rd_en), .rd_data (rdata[1]),
        .rd_valid (rvalid[1]), .empty (empty[1]), .almost_empty (aempty[1]),
        .underflow (unf[1]), .data_count (cnt[1])
`ifdef FIFO_SYN_WATERMARK_EN
        , .peak_clr (peak_clr), .peak_count (peak[1])
`endif
    );

    // Reference model: std is one queue; fwft is a storage queue plus a head register.
    logic [DW-1:0] q_s [$];
    logic [DW-1:0] q_f [$];
    logic [DW-1:0] s_rdata, f_od;
    bit            s_valid, f_ov;
    bit            e_ovf [2];
    bit            e_unf [2];
    int            n_cmp, n_err, cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        int  cs, cf;
        bit  pop, pre;
        cs = q_s.size();
        cf = q_f.size() + int'(f_ov);
        if (rst) begin
            q_s.delete();
            q_f.delete();
            s_valid = 1'b0;
            s_rdata = '0;
            f_ov    = 1'b0;
            f_od    = '0;
            for (int m = 0; m < 2; m++) begin
                e_ovf[m] = 1'b0;
                e_unf[m] = 1'b0;
            end
`ifdef FIFO_SYN_WATERMARK_EN
            e_peak[0] = 0;
            e_peak[1] = 0;
`endif
            return;
        end
`ifdef FIFO_SYN_WATERMARK_EN
        if (peak_clr) begin
            e_peak[0] = cs;
            e_peak[1] = cf;
        end else begin
            if (cs > e_peak[0]) e_peak[0] = cs;
            if (cf > e_peak[1]) e_peak[1] = cf;
        end
`endif
        e_ovf[0] = wr_en && (cs == DEPTH);
        e_unf[0] = rd_en && (cs == 0);
        s_valid  = rd_en && (cs != 0);
        if (s_valid) s_rdata = q_s.pop_front();
        if (wr_en && cs != DEPTH) q_s.push_back(wr_data);

        pop      = rd_en && f_ov;
        e_ovf[1] = wr_en && (cf == DEPTH);
        e_unf[1] = rd_en && !f_ov;
        pre      = (q_f.size() != 0) && (!f_ov || pop);
        if (pop) f_ov = 1'b0;
        if (pre) begin
            f_od = q_f.pop_front();
            f_ov = 1'b1;
        end
        if (wr_en && cf != DEPTH) q_f.push_back(wr_data);
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int    c;
            string p;
            p = (m == 0) ? "std" : "fwft";
            c = (m == 0) ? q_s.size() : q_f.size() + int'(f_ov);
            check_eq({p, ".data_count"}, 64'(cnt[m]), 64'(c));
            check_eq({p, ".full"}, 64'(full[m]), 64'(c == DEPTH));
            check_eq({p, ".almost_full"}, 64'(afull[m]), 64'(c >= AFT));
            check_eq({p, ".almost_empty"}, 64'(aempty[m]), 64'(c <= AET));
            check_eq({p, ".empty"}, 64'(empty[m]), 64'((m == 0) ? (c == 0) : !f_ov));
            check_eq({p, ".rd_valid"}, 64'(rvalid[m]), 64'((m == 0) ? s_valid : f_ov));
            check_eq({p, ".rd_data"}, 64'(rdata[m]), 64'((m == 0) ? s_rdata : f_od));
            check_eq({p, ".overflow"}, 64'(ovf[m]), 64'(e_ovf[m]));
            check_eq({p, ".underflow"}, 64'(unf[m]), 64'(e_unf[m]));
`ifdef FIFO_SYN_WATERMARK_EN
            check_eq({p, ".peak_count"}, 64'(peak[m]), 64'(e_peak[m]));
`endif
        end
    endtask

    task automatic tick(input bit r, input bit w, input bit rd, input logic [DW-1:0] d,
                        input bit clr);
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        wr_data = d;
`ifdef FIFO_SYN_WATERMARK_EN
        peak_clr = clr;
`else
        if (clr) $display("note: peak_clr ignored without watermark");
`endif
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        tick(1, 0, 0, '0, 0);
        tick(1, 0, 0, '0, 0);
        // Fill 0..15, then a 17th write that must overflow.
        for (int i = 0; i < 17; i++) tick(0, 1, 0, DW'(i), 0);
        tick(0, 0, 0, '0, 0);
        // Drain 16 words plus one underflowing read.
        for (int i = 0; i < 17; i++) tick(0, 0, 1, '0, 0);
        tick(0, 0, 0, '0, 0);
        // Hold occupancy at 8 across several pointer laps.
        for (int i = 0; i < 8; i++) tick(0, 1, 0, DW'($urandom), 0);
        for (int i = 0; i < 100; i++) tick(0, 1, 1, DW'($urandom), 0);
        // Random traffic, write-biased then read-biased to hit both boundaries.
        for (int i = 0; i < 150; i++)
            tick(0, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, DW'($urandom), 0);
        for (int i = 0; i < 150; i++)
            tick(0, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, DW'($urandom), 0);
        // Drain, build to 9, reset mid-burst, then post-reset traffic.
        for (int i = 0; i < 20; i++) tick(0, 0, 1, '0, 0);
        for (int i = 0; i < 9; i++) tick(0, 1, 0, DW'($urandom), 0);
        tick(1, 1, 0, DW'($urandom), 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, DW'($urandom), 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, '0, 0);
        // Single word into an empty FIFO.
        tick(0, 1, 0, DW'(16'h00A5), 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, '0, 0);
        tick(0, 0, 1, '0, 0);
        // Ten queued words read back continuously.
        for (int i = 0; i < 10; i++) tick(0, 1, 0, DW'($urandom), 0);
        for (int i = 0; i < 12; i++) tick(0, 0, 1, '0, 0);
        // Watermark scenario: fill to 11, drain to 2, then clear.
        tick(1, 0, 0, '0, 0);
        for (int i = 0; i < 11; i++) tick(0, 1, 0, DW'($urandom), 0);
        for (int i = 0; i < 9; i++) tick(0, 0, 1, '0, 0);
        tick(0, 0, 0, '0, 0);
`ifdef FIFO_SYN_WATERMARK_EN
        tick(0, 0, 0, '0, 1);
`endif
        tick(0, 0, 0, '0, 0);
        tick(0, 0, 0, '0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
